// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN layer sequencer.
//   state_e        - sequencer FSM states
//   STG_*          - err_stage encodings reported on timeout
//   DEFAULT_TIMEOUT_CYCLES - default per-stage stall limit
//   stage_code()   - maps a layer state to its err_stage encoding
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    RELU = 3'd2,
    POOL = 3'd3,
    NEXT = 3'd4,
    ERR  = 3'd5
  } state_e;

  localparam logic [1:0] STG_NONE = 2'd0;
  localparam logic [1:0] STG_CONV = 2'd1;
  localparam logic [1:0] STG_RELU = 2'd2;
  localparam logic [1:0] STG_POOL = 2'd3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  function automatic logic [1:0] stage_code(input state_e s);
    case (s)
      CONV:    return STG_CONV;
      RELU:    return STG_RELU;
      POOL:    return STG_POOL;
      default: return STG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/stage_timer.sv
// stage_timer: per-stage cycle counter shared by the conv/relu/pool stages.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clear     - zero the counter (takes priority over enable)
//   enable    - count one cycle
//   count     - current count (0 on the first cycle of a stage)
//   timeout   - high while enabled and count has reached LIMIT-1
module stage_timer
  import cnn_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign timeout = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs conv -> relu -> pool for each image of a batch.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   start, abort        - batch start request / cancel
//   cfg_num_images      - batch size, latched on an accepted start
//   conv/relu/pool_done - completion from each layer
//   conv/relu/pool_enable - level enables to each layer
//   img_idx             - 0-based image in progress
//   busy, done          - batch running / one-cycle batch-complete pulse
//   error, err_stage    - sticky stall flag and the stage that stalled
//   stage_cycles        - enable-high cycles of the last completed stage
//
// state | meaning
// IDLE  | waiting for start
// CONV  | conv_enable high, waiting for conv_done
// RELU  | relu_enable high, waiting for relu_done
// POOL  | pool_enable high, waiting for pool_done
// NEXT  | one cycle: advance image index or finish batch
// ERR   | a stage timed out; waits for start
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16,
  parameter int IMG_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IMG_W-1:0] cfg_num_images,
  input  logic             conv_done,
  input  logic             relu_done,
  input  logic             pool_done,
  output logic             conv_enable,
  output logic             relu_enable,
  output logic             pool_enable,
  output logic [IMG_W-1:0] img_idx,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_stage,
  output logic [CNT_W-1:0] stage_cycles
);

  state_e           state_q, state_d;
  logic [IMG_W-1:0] num_q, num_d;
  logic [IMG_W-1:0] img_idx_q, img_idx_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_stage_q, err_stage_d;
  logic [CNT_W-1:0] stage_cycles_q, stage_cycles_d;
  logic             conv_en_q, conv_en_d;
  logic             relu_en_q, relu_en_d;
  logic             pool_en_q, pool_en_d;
  logic             busy_q, busy_d;

  logic             in_stage;
  logic             next_in_stage;
  logic             stage_done;
  logic             tmr_clear;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_timeout;

  assign in_stage      = (state_q == CONV) || (state_q == RELU) || (state_q == POOL);
  assign next_in_stage = (state_d == CONV) || (state_d == RELU) || (state_d == POOL);

  // Only the done of the layer currently enabled is looked at, so a stale
  // or early done from another layer can never advance the sequence.
  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      CONV:    stage_done = conv_done;
      RELU:    stage_done = relu_done;
      POOL:    stage_done = pool_done;
      default: stage_done = 1'b0;
    endcase
  end

  // Counter restarts on every stage entry, including CONV->CONV via NEXT.
  assign tmr_clear = next_in_stage && (state_d != state_q);

  stage_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_stage_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (in_stage),
    .count   (tmr_count),
    .timeout (tmr_timeout)
  );

  always_comb begin
    state_d        = state_q;
    num_d          = num_q;
    img_idx_d      = img_idx_q;
    done_d         = 1'b0;
    error_d        = error_q;
    err_stage_d    = err_stage_q;
    stage_cycles_d = stage_cycles_q;

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          error_d     = 1'b0;
          err_stage_d = STG_NONE;
          if (cfg_num_images != '0) begin
            num_d     = cfg_num_images;
            img_idx_d = '0;
            state_d   = CONV;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CONV, RELU, POOL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (stage_done) begin
          // done beats a coincident timeout
          stage_cycles_d = tmr_count + CNT_W'(1);
          case (state_q)
            CONV:    state_d = RELU;
            RELU:    state_d = POOL;
            default: state_d = NEXT;
          endcase
        end else if (tmr_timeout) begin
          state_d     = ERR;
          error_d     = 1'b1;
          err_stage_d = stage_code(state_q);
        end
      end
      NEXT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (img_idx_q == num_q - IMG_W'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          img_idx_d = img_idx_q + IMG_W'(1);
          state_d   = CONV;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode so each
    // enable is high exactly while the FSM sits in its state.
    conv_en_d = (state_d == CONV);
    relu_en_d = (state_d == RELU);
    pool_en_d = (state_d == POOL);
    busy_d    = next_in_stage || (state_d == NEXT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      num_q          <= '0;
      img_idx_q      <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_stage_q    <= STG_NONE;
      stage_cycles_q <= '0;
      conv_en_q      <= 1'b0;
      relu_en_q      <= 1'b0;
      pool_en_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_q          <= num_d;
      img_idx_q      <= img_idx_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_stage_q    <= err_stage_d;
      stage_cycles_q <= stage_cycles_d;
      conv_en_q      <= conv_en_d;
      relu_en_q      <= relu_en_d;
      pool_en_q      <= pool_en_d;
      busy_q         <= busy_d;
    end
  end

  assign conv_enable  = conv_en_q;
  assign relu_enable  = relu_en_q;
  assign pool_enable  = pool_en_q;
  assign img_idx      = img_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_stage    = err_stage_q;
  assign stage_cycles = stage_cycles_q;

endmodule
